// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter_pkg: shared state encoding, per-channel request bundle and arbitration modes
package dbus_arbiter_pkg;
  typedef enum logic {IDLE, REQ} arb_state_t;
  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_chreq_t;
  localparam int ARB_RR = 0;
  localparam int ARB_PRIO = 1;
endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// rr_pick: picks the first eligible index at or above a start pointer, wrapping to the lowest
module rr_pick #(
  parameter int N = 3,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] rr_ptr,
  input  logic         mode,
  output logic [W-1:0] winner,
  output logic         any
);
  logic [W-1:0] start, hi_w, lo_w;
  logic hi_found;
  always_comb begin
    start = mode ? '0 : rr_ptr;
    hi_w = '0;
    lo_w = '0;
    hi_found = 1'b0;
    any = 1'b0;
    // descending scan: the last hit is the lowest index, overall and at/above start
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_w = W'(i);
        any = 1'b1;
        if (W'(i) >= start) begin
          hi_w = W'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_w : lo_w;
  end
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: merges N_CH memory-request channels onto one dbus port with a single
// outstanding transaction, per-channel kill of the response and an optional watchdog
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int ARB_MODE = ARB_RR,
  parameter int TIMEOUT = 0,
  localparam int GW = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_CH-1:0]    ch_req,
  input  logic [N_CH*64-1:0] ch_addr,
  input  logic [N_CH*3-1:0]  ch_size,
  input  logic [N_CH*8-1:0]  ch_strobe,
  input  logic [N_CH*64-1:0] ch_wdata,
  input  logic [N_CH-1:0]    ch_kill,
  output logic [N_CH-1:0]    ch_ok,
  output logic [63:0]        ch_rdata,
  output logic               dreq_valid,
  output logic [63:0]        dreq_addr,
  output logic [2:0]         dreq_size,
  output logic [7:0]         dreq_strobe,
  output logic [63:0]        dreq_data,
  input  logic               dresp_data_ok,
  input  logic [63:0]        dresp_data,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               err
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  arb_state_t state_q, state_d;
  dbus_chreq_t req_q, req_d, sel;
  logic dreq_valid_q, dreq_valid_d, kill_q, kill_d, kill_ch, killed, err_q, err_d, any;
  logic [N_CH-1:0] eligible, ch_ok_q, ch_ok_d;
  logic [63:0] ch_rdata_q, ch_rdata_d;
  logic [GW-1:0] grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, winner;
  logic [TW-1:0] timer_q, timer_d;

  // a channel completing this cycle sits out the grant made in the same cycle
  assign eligible = ch_req & ~ch_kill & ~ch_ok_q;

  rr_pick #(.N(N_CH)) u_pick (
    .eligible(eligible),
    .rr_ptr(rr_ptr_q),
    .mode(ARB_MODE == ARB_PRIO),
    .winner(winner),
    .any(any)
  );

  always_comb begin
    sel = '0;
    kill_ch = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (winner == GW'(i)) sel = {ch_addr[i*64 +: 64], ch_size[i*3 +: 3], ch_strobe[i*8 +: 8], ch_wdata[i*64 +: 64]};
      if (grant_id_q == GW'(i)) kill_ch = ch_kill[i];
    end
  end

  assign killed = kill_q | kill_ch;

  always_comb begin
    state_d = state_q;
    req_d = req_q;
    dreq_valid_d = dreq_valid_q;
    ch_ok_d = '0;
    ch_rdata_d = ch_rdata_q;
    grant_id_d = grant_id_q;
    rr_ptr_d = rr_ptr_q;
    kill_d = kill_q;
    timer_d = timer_q;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (any) begin
        state_d = REQ;
        req_d = sel;
        dreq_valid_d = 1'b1;
        grant_id_d = winner;
        kill_d = 1'b0;
        timer_d = '0;
      end
    end else if (dresp_data_ok) begin
      state_d = IDLE;
      dreq_valid_d = 1'b0;
      kill_d = 1'b0;
      rr_ptr_d = grant_id_q == GW'(N_CH - 1) ? '0 : grant_id_q + 1'b1;
      ch_ok_d = killed ? '0 : N_CH'(1) << grant_id_q;
      ch_rdata_d = killed ? ch_rdata_q : dresp_data;
    end else begin
      kill_d = killed;
      if (TIMEOUT > 0) begin
        timer_d = timer_q + 1'b1;
        err_d = timer_d == TW'(TIMEOUT);
        timer_d = err_d ? '0 : timer_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q <= '0;
      dreq_valid_q <= 1'b0;
      ch_ok_q <= '0;
      ch_rdata_q <= '0;
      grant_id_q <= '0;
      rr_ptr_q <= '0;
      kill_q <= 1'b0;
      timer_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      dreq_valid_q <= dreq_valid_d;
      ch_ok_q <= ch_ok_d;
      ch_rdata_q <= ch_rdata_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q <= rr_ptr_d;
      kill_q <= kill_d;
      timer_q <= timer_d;
      err_q <= err_d;
    end
  end

  assign dreq_valid = dreq_valid_q;
  assign dreq_addr = req_q.addr;
  assign dreq_size = req_q.size;
  assign dreq_strobe = req_q.strobe;
  assign dreq_data = req_q.data;
  assign ch_ok = ch_ok_q;
  assign ch_rdata = ch_rdata_q;
  assign grant_id = grant_id_q;
  assign err = err_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed scoreboard bench for a round-robin/watchdog and a fixed-priority arbiter
module tb_dbus_arbiter;
  localparam int N = 3;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] a0 = 64'h8000_0100, a1 = 64'h8000_0200, a2 = 64'h8000_0300;
  logic [N*64-1:0] ch_addr;
  assign ch_addr = {a2, a1, a0};
  logic [N*3-1:0] ch_size = {3'd3, 3'd3, 3'd3};
  logic [N*8-1:0] ch_strobe = '0;
  logic [N*64-1:0] ch_wdata = '0;
  logic [N-1:0] req = '0, kill = '0, p_req = '0, p_kill = '0;
  logic data_ok = 1'b0, p_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;

  logic [N-1:0] r_ok, p_ok;
  logic [63:0] r_rdata, r_addr, r_data, p_rdata, p_addr, p_data;
  logic [2:0] r_size, p_size;
  logic [7:0] r_strobe, p_strobe;
  logic r_valid, r_busy, r_err, p_valid, p_busy, p_err, r_vprev = 1'b0, p_vprev = 1'b0;
  logic [1:0] r_gid, p_gid;

  dbus_arbiter #(.N_CH(N), .ARB_MODE(0), .TIMEOUT(4)) u_rr (
    .clk(clk), .reset(reset), .ch_req(req), .ch_addr(ch_addr), .ch_size(ch_size),
    .ch_strobe(ch_strobe), .ch_wdata(ch_wdata), .ch_kill(kill), .ch_ok(r_ok), .ch_rdata(r_rdata),
    .dreq_valid(r_valid), .dreq_addr(r_addr), .dreq_size(r_size), .dreq_strobe(r_strobe),
    .dreq_data(r_data), .dresp_data_ok(data_ok), .dresp_data(dresp_data), .busy(r_busy),
    .grant_id(r_gid), .err(r_err)
  );

  dbus_arbiter #(.N_CH(N), .ARB_MODE(1), .TIMEOUT(0)) u_pr (
    .clk(clk), .reset(reset), .ch_req(p_req), .ch_addr(ch_addr), .ch_size(ch_size),
    .ch_strobe(ch_strobe), .ch_wdata(ch_wdata), .ch_kill(p_kill), .ch_ok(p_ok), .ch_rdata(p_rdata),
    .dreq_valid(p_valid), .dreq_addr(p_addr), .dreq_size(p_size), .dreq_strobe(p_strobe),
    .dreq_data(p_data), .dresp_data_ok(p_data_ok), .dresp_data(dresp_data), .busy(p_busy),
    .grant_id(p_gid), .err(p_err)
  );

  logic [66:0] ok_q[$], p_okq[$];
  logic [65:0] grant_q[$], p_gq[$];
  int err_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst dreq_valid", r_valid, 0);
    check("rst busy", r_busy, 0);
    check("rst ch_ok", r_ok, 0);
    check("rst grant_id", r_gid, 0);
    check("rst err", r_err, 0);
    check("rst dreq_addr", r_addr, 0);
    check("rst prio dreq_valid", p_valid, 0);
    req = '0; p_req = '0; kill = '0; data_ok = 1'b0; p_data_ok = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (r_ok != '0) begin
        if (ok_q.size() == 0) check("unexpected ch_ok", {r_ok, r_rdata}, 0);
        else check("ch_ok/rdata", {r_ok, r_rdata}, ok_q.pop_front());
      end
      if (r_valid && !r_vprev) begin
        if (grant_q.size() == 0) check("unexpected grant", {r_gid, r_addr}, 0);
        else check("grant_id/addr", {r_gid, r_addr}, grant_q.pop_front());
      end
      if (r_err) begin
        if (err_q.size() == 0) check("unexpected err", r_err, 0);
        else check("err cycle", cyc, err_q.pop_front());
      end
      if (p_ok != '0) begin
        if (p_okq.size() == 0) check("prio unexpected ch_ok", {p_ok, p_rdata}, 0);
        else check("prio ch_ok/rdata", {p_ok, p_rdata}, p_okq.pop_front());
      end
      if (p_valid && !p_vprev) begin
        if (p_gq.size() == 0) check("prio unexpected grant", {p_gid, p_addr}, 0);
        else check("prio grant_id/addr", {p_gid, p_addr}, p_gq.pop_front());
      end
      if (p_err) check("prio err disabled", p_err, 0);
    end
    r_vprev <= r_valid;
    p_vprev <= p_valid;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: cycle %0d reached without finishing", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    #2;
    do_reset();
    // single read, data_ok three cycles after the grant
    req = 3'b001;
    grant_q.push_back({2'd0, a0});
    ok_q.push_back({3'b001, 64'hDEAD});
    tick(1);
    check("t1 dreq_valid at t+1", r_valid, 1);
    tick(2);
    data_ok = 1'b1; dresp_data = 64'hDEAD;
    tick(1);
    check("t1 ch_ok at k+1", r_ok, 3'b001);
    data_ok = 1'b0; req = '0;
    tick(1);
    check("t1 idle", r_busy, 0);
    do_reset();
    // round-robin fairness with every channel requesting
    req = 3'b111; data_ok = 1'b1; dresp_data = 64'hA5A5;
    for (int i = 0; i < 6; i++) begin
      grant_q.push_back({2'(i % 3), (i % 3 == 0) ? a0 : (i % 3 == 1) ? a1 : a2});
      ok_q.push_back({3'(1 << (i % 3)), 64'hA5A5});
    end
    tick(12);
    req = '0; data_ok = 1'b0;
    tick(2);
    do_reset();
    // kill of an in-flight ch2 request, then ch1 granted right after
    req = 3'b100;
    grant_q.push_back({2'd2, a2});
    tick(1);
    req = 3'b110; kill = 3'b100;
    tick(1);
    kill = '0; req = 3'b010; data_ok = 1'b1; dresp_data = 64'hBAD;
    tick(1);
    check("t4 killed no ch_ok", r_ok, 0);
    check("t4 dreq dropped", r_valid, 0);
    grant_q.push_back({2'd1, a1});
    ok_q.push_back({3'b010, 64'hBEEF});
    dresp_data = 64'hBEEF;
    tick(1);
    check("t4 next grant", r_gid, 1);
    tick(1);
    req = '0; data_ok = 1'b0;
    tick(1);
    // kill coinciding with data_ok
    req = 3'b001;
    grant_q.push_back({2'd0, a0});
    tick(1);
    kill = 3'b001; data_ok = 1'b1;
    tick(1);
    check("t4 kill beats data_ok", r_ok, 0);
    kill = '0; data_ok = 1'b0; req = '0;
    tick(2);
    do_reset();
    // back-to-back grant then asynchronous reset mid-transaction
    req = 3'b011;
    grant_q.push_back({2'd0, a0});
    ok_q.push_back({3'b001, 64'h5A5A});
    grant_q.push_back({2'd1, a1});
    tick(1);
    data_ok = 1'b1; dresp_data = 64'h5A5A;
    tick(1);
    data_ok = 1'b0; req = 3'b010;
    tick(1);
    check("t5 busy before reset", r_busy, 1);
    #5;
    do_reset();
    // watchdog: no data_ok, err every 4 REQ cycles, request held
    c = cyc;
    req = 3'b100;
    grant_q.push_back({2'd2, a2});
    err_q.push_back(c + 5);
    err_q.push_back(c + 9);
    tick(1);
    a2 = 64'hFFFF_0000;
    tick(9);
    check("t6 dreq_addr held", r_addr, 64'h8000_0300);
    check("t6 dreq_valid held", r_valid, 1);
    data_ok = 1'b1; dresp_data = 64'h600D;
    ok_q.push_back({3'b100, 64'h600D});
    tick(1);
    data_ok = 1'b0; req = '0; a2 = 64'h8000_0300;
    tick(2);
    // fixed priority: 110 then 111 -> 1,0,1,0 with ch2 starved
    p_req = 3'b110; p_data_ok = 1'b1;
    p_gq.push_back({2'd1, a1});
    p_gq.push_back({2'd0, a0});
    p_gq.push_back({2'd1, a1});
    p_gq.push_back({2'd0, a0});
    p_okq.push_back({3'b010, 64'h600D});
    p_okq.push_back({3'b001, 64'h600D});
    p_okq.push_back({3'b010, 64'h600D});
    p_okq.push_back({3'b001, 64'h600D});
    tick(1);
    p_req = 3'b111;
    tick(7);
    p_req = '0; p_data_ok = 1'b0;
    tick(3);
    check("ok queue drained", ok_q.size(), 0);
    check("grant queue drained", grant_q.size(), 0);
    check("err queue drained", err_q.size(), 0);
    check("prio ok queue drained", p_okq.size(), 0);
    check("prio grant queue drained", p_gq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
